// File: rtl/mips_run_ctrl_pkg.sv
// Shared definitions for the MIPS run controller: state encoding and default parameters.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RUN      = 3'd2,
        ST_PAUSE    = 3'd3,
        ST_STEP     = 3'd4,
        ST_HALT     = 3'd5
    } run_state_t;

    localparam int DEF_NUM_CORES = 1;
    localparam int DEF_RST_HOLD  = 4;
    localparam int DEF_CNT_W     = 32;
    localparam int DEF_STEP_W    = 8;

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Control/status bundle between a run-control master (board or bench) and the controller.
interface mips_run_ctrl_if
    import mips_ctrl_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int STEP_W    = DEF_STEP_W
);

    logic                 start;
    logic                 stop;
    logic                 step_mode;
    logic                 step_req;
    logic [STEP_W-1:0]    step_count;
    logic [CNT_W-1:0]     max_cycles;
    logic [NUM_CORES-1:0] core_mask;

    logic [NUM_CORES-1:0] core_rst_n;
    logic [NUM_CORES-1:0] core_en;
    logic [2:0]           state;
    logic [CNT_W-1:0]     cycle_count;
    logic                 done;
    logic                 timeout;

    modport master (
        output start, stop, step_mode, step_req, step_count, max_cycles, core_mask,
        input  core_rst_n, core_en, state, cycle_count, done, timeout
    );

    modport slave (
        input  start, stop, step_mode, step_req, step_count, max_cycles, core_mask,
        output core_rst_n, core_en, state, cycle_count, done, timeout
    );

endinterface

// File: rtl/mips_run_ctrl_reset_sync.sv
// Two-flop reset synchronizer: assertion is asynchronous, release is aligned to clk.
module reset_sync (
    input  logic clk,
    input  logic arst_n,
    output logic sync_rst_n
);

    logic meta_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta_q     <= 1'b0;
            sync_rst_n <= 1'b0;
        end else begin
            meta_q     <= 1'b1;
            sync_rst_n <= meta_q;
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for MIPS cores: sequenced core reset release, free-run / step / halt
// modes, enabled-cycle budget with timeout, and per-core clock enables.
module mips_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int RST_HOLD  = DEF_RST_HOLD,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int STEP_W    = DEF_STEP_W
) (
    input  logic            clk,
    input  logic            reset,
    mips_run_ctrl_if.slave  bus
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    logic              sync_rst_n;
    run_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [CNT_W-1:0]  cycle_q;
    logic [CNT_W:0]    cycle_inc;
    logic              core_rst_q;
    logic              done_q;
    logic              timeout_q;
    logic              enabled;
    logic              budget_hit;
    logic              budget_halt;
    logic              restart;

    reset_sync u_reset_sync (
        .clk        (clk),
        .arst_n     (reset),
        .sync_rst_n (sync_rst_n)
    );

    assign enabled    = (state_q == ST_RUN) || (state_q == ST_STEP);
    // Compared one bit wider so a saturated counter can never alias onto a budget.
    assign cycle_inc  = {1'b0, cycle_q} + (CNT_W + 1)'(1);
    assign budget_hit = enabled && (bus.max_cycles != '0) &&
                        (cycle_inc == {1'b0, bus.max_cycles});

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        step_d      = step_q;
        budget_halt = 1'b0;
        restart     = 1'b0;
        case (state_q)
            ST_RST_HOLD: begin
                if (sync_rst_n) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            ST_IDLE: begin
                if (bus.stop) begin
                    state_d = ST_HALT;
                end else if (bus.start) begin
                    state_d = bus.step_mode ? ST_PAUSE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_HALT;
                end else if (budget_hit) begin
                    state_d     = ST_HALT;
                    budget_halt = 1'b1;
                end else if (bus.step_mode) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    state_d = ST_HALT;
                end else if (bus.step_req) begin
                    state_d = ST_STEP;
                    step_d  = (bus.step_count == '0) ? STEP_W'(1) : bus.step_count;
                end else if (bus.start && !bus.step_mode) begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                if (bus.stop) begin
                    state_d = ST_HALT;
                end else if (budget_hit) begin
                    state_d     = ST_HALT;
                    budget_halt = 1'b1;
                end else begin
                    step_d = step_q - STEP_W'(1);
                    if (step_q <= STEP_W'(1)) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_HALT: begin
                if (bus.start) begin
                    state_d = ST_RST_HOLD;
                    hold_d  = '0;
                    restart = 1'b1;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Core reset and done are registered from the next state so they change on the
    // same edge as the state itself and never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RST_HOLD;
            hold_q     <= '0;
            step_q     <= '0;
            cycle_q    <= '0;
            core_rst_q <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            step_q     <= step_d;
            core_rst_q <= (state_d != ST_RST_HOLD);
            done_q     <= (state_d == ST_HALT);
            if (restart) begin
                cycle_q   <= '0;
                timeout_q <= 1'b0;
            end else begin
                if (enabled && (cycle_q != '1)) begin
                    cycle_q <= cycle_inc[CNT_W-1:0];
                end
                if (budget_halt) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.core_rst_n  = {NUM_CORES{core_rst_q}};
    assign bus.core_en     = enabled ? bus.core_mask : '0;
    assign bus.state       = state_q;
    assign bus.cycle_count = cycle_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Randomized scenario bench for mips_run_ctrl, checked against enabled-cycle arithmetic.
module tb_mips_run_ctrl;

    localparam int NC = 2;
    localparam int RH = 4;
    localparam int CW = 32;
    localparam int SW = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mips_run_ctrl_if #(.NUM_CORES(NC), .CNT_W(CW), .STEP_W(SW)) bus ();

    mips_run_ctrl #(
        .NUM_CORES (NC),
        .RST_HOLD  (RH),
        .CNT_W     (CW),
        .STEP_W    (SW)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.step_mode  = 1'b0;
        bus.step_req   = 1'b0;
        bus.step_count = '0;
        bus.max_cycles = '0;
        bus.core_mask  = 2'b11;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (RH + 4) tick();
    endtask

    task automatic pulse_start;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        idle_inputs();
        rst_n = 1'b0;
        #3;
        checks++;
        if (bus.state !== 3'd0 || bus.core_rst_n !== 2'b00 || bus.core_en !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_hold: state=%0d rst_n=%b en=%b expected 0/00/00",
                     bus.state, bus.core_rst_n, bus.core_en);
        end
        checks++;
        if (bus.cycle_count !== 32'd0 || bus.done !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_status: cnt=%0d done=%b to=%b expected 0/0/0",
                     bus.cycle_count, bus.done, bus.timeout);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (bus.core_rst_n === 2'b11) break;
        end
        checks++;
        if (n != 2 + RH) begin
            errors++;
            $display("[TB] FAIL reset_release_edges: got %0d expected %0d", n, 2 + RH);
        end
        checks++;
        if (bus.state !== 3'd1 || bus.core_en !== 2'b00 || bus.done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: state=%0d en=%b done=%b expected 1/00/0",
                     bus.state, bus.core_en, bus.done);
        end
    endtask

    task automatic test_free_run;
        logic [1:0] mask;
        int         maxc;
        int         en_cnt;
        bit         halted;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            mask = (it == 0) ? 2'b11 : 2'($urandom_range(1, 3));
            maxc = (it == 0) ? 10 : int'($urandom_range(1, 30));
            bus.core_mask  = mask;
            bus.max_cycles = CW'(maxc);
            pulse_start();
            en_cnt = 0;
            halted = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (bus.state === 3'd5) begin
                    halted = 1'b1;
                    break;
                end
                if (bus.core_en !== 2'b00) begin
                    en_cnt++;
                    checks++;
                    if (bus.core_en !== mask) begin
                        errors++;
                        $display("[TB] FAIL run_mask: got %b expected %b", bus.core_en, mask);
                    end
                end
                tick();
            end
            checks++;
            if (!halted || en_cnt != maxc) begin
                errors++;
                $display("[TB] FAIL run_enabled_cycles: got %0d (halted=%0d) expected %0d",
                         en_cnt, halted, maxc);
            end
            checks++;
            if (bus.done !== 1'b1 || bus.timeout !== 1'b1 || bus.cycle_count !== CW'(maxc)) begin
                errors++;
                $display("[TB] FAIL run_budget_halt: done=%b to=%b cnt=%0d expected 1/1/%0d",
                         bus.done, bus.timeout, bus.cycle_count, maxc);
            end
        end
    endtask

    task automatic test_restart;
        int n;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.state !== 3'd0 || bus.core_rst_n !== 2'b00 || bus.cycle_count !== 32'd0 ||
            bus.done !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_entry: state=%0d rst_n=%b cnt=%0d done=%b to=%b expected 0/00/0/0/0",
                     bus.state, bus.core_rst_n, bus.cycle_count, bus.done, bus.timeout);
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (bus.core_rst_n === 2'b11) break;
        end
        checks++;
        if (n != RH || bus.state !== 3'd1) begin
            errors++;
            $display("[TB] FAIL restart_hold: edges=%0d state=%0d expected %0d/1", n, bus.state, RH);
        end
    endtask

    task automatic test_stepping;
        int  sc_list[$];
        int  total;
        int  n;
        int  exp_n;
        bit  back;
        apply_reset();
        bus.step_mode = 1'b1;
        pulse_start();
        checks++;
        if (bus.state !== 3'd3 || bus.core_en !== 2'b00) begin
            errors++;
            $display("[TB] FAIL step_pause_entry: state=%0d en=%b expected 3/00", bus.state, bus.core_en);
        end
        sc_list = '{3, 0};
        for (int i = 0; i < 3; i++) sc_list.push_back(int'($urandom_range(0, 6)));
        total = 0;
        foreach (sc_list[k]) begin
            bus.step_count = SW'(sc_list[k]);
            bus.step_req   = 1'b1;
            tick();
            bus.step_req = 1'b0;
            n    = 0;
            back = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (bus.state === 3'd3) begin
                    back = 1'b1;
                    break;
                end
                if (bus.core_en !== 2'b00) n++;
                tick();
            end
            exp_n = (sc_list[k] == 0) ? 1 : sc_list[k];
            total += exp_n;
            checks++;
            if (!back || n != exp_n) begin
                errors++;
                $display("[TB] FAIL step_burst: step_count=%0d got %0d cycles (paused=%0d) expected %0d",
                         sc_list[k], n, back, exp_n);
            end
        end
        checks++;
        if (bus.cycle_count !== CW'(total) || bus.timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL step_total: cnt=%0d to=%b expected %0d/0", bus.cycle_count, bus.timeout, total);
        end
    endtask

    task automatic test_stop_priority;
        int maxc;
        apply_reset();
        maxc = int'($urandom_range(4, 20));
        bus.core_mask  = 2'b01;
        bus.max_cycles = CW'(maxc);
        pulse_start();
        checks++;
        if (bus.core_en !== 2'b01) begin
            errors++;
            $display("[TB] FAIL stop_mask: got %b expected 01", bus.core_en);
        end
        repeat (maxc - 1) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++;
        if (bus.state !== 3'd5 || bus.timeout !== 1'b0 || bus.done !== 1'b1 ||
            bus.cycle_count !== CW'(maxc)) begin
            errors++;
            $display("[TB] FAIL stop_priority: state=%0d to=%b done=%b cnt=%0d expected 5/0/1/%0d",
                     bus.state, bus.timeout, bus.done, bus.cycle_count, maxc);
        end
    endtask

    task automatic test_budget_lowered;
        apply_reset();
        pulse_start();
        repeat (8) tick();
        bus.max_cycles = CW'($urandom_range(1, 7));
        bus.step_req   = 1'b1;
        repeat (10) tick();
        bus.step_req = 1'b0;
        checks++;
        if (bus.state !== 3'd2 || bus.cycle_count !== 32'd18 || bus.timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL budget_lowered: state=%0d cnt=%0d to=%b expected 2/18/0",
                     bus.state, bus.cycle_count, bus.timeout);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++;
        if (bus.state !== 3'd5 || bus.done !== 1'b1 || bus.cycle_count !== 32'd19) begin
            errors++;
            $display("[TB] FAIL stop_from_run: state=%0d done=%b cnt=%0d expected 5/1/19",
                     bus.state, bus.done, bus.cycle_count);
        end
    endtask

    task automatic test_async_reset_mid_step;
        apply_reset();
        bus.step_mode = 1'b1;
        pulse_start();
        bus.step_count = 8'd5;
        bus.step_req   = 1'b1;
        tick();
        bus.step_req = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.cycle_count !== 32'd2 || bus.core_en !== 2'b11 || bus.state !== 3'd4) begin
            errors++;
            $display("[TB] FAIL mid_step: cnt=%0d en=%b state=%0d expected 2/11/4",
                     bus.cycle_count, bus.core_en, bus.state);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.core_en !== 2'b00 || bus.core_rst_n !== 2'b00 || bus.state !== 3'd0 ||
            bus.cycle_count !== 32'd0 || bus.done !== 1'b0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: en=%b rst_n=%b state=%0d cnt=%0d done=%b to=%b expected all zero",
                     bus.core_en, bus.core_rst_n, bus.state, bus.cycle_count, bus.done, bus.timeout);
        end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_free_run();
        test_restart();
        test_stepping();
        test_stop_priority();
        test_budget_lowered();
        test_async_reset_mid_step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Synthesizable run controller for one or more MIPS pipeline cores. It replaces the fixed clock/reset-only stimulus with a sequenced, parametrised core reset release and a per-core clock-enable. It adds free-run, single/multi-step and halt modes, a cycle budget with timeout, and an enabled-cycle counter. It sits between the board/bench clock/reset and the cores' reset and enable inputs.

Parameters:
NUM_CORES, 1, number of cores controlled (width of core vectors)
RST_HOLD, 4, cycles core reset is held low after synchronized reset release or soft restart (>=1)
CNT_W, 32, width of cycle counter and cycle budget
STEP_W, 8, width of step count

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  level: leave IDLE / resume from PAUSE / restart from HALT
stop  input  1  level: force HALT
step_mode  input  1  1 = stepping mode, 0 = free run
step_req  input  1  in PAUSE: issue one step burst
step_count  input  STEP_W  enabled cycles per step burst (0 treated as 1)
max_cycles  input  CNT_W  enabled-cycle budget, 0 = unlimited
core_mask  input  NUM_CORES  per-core enable mask
core_rst_n  output  NUM_CORES  active-low core resets, all bits identical
core_en  output  NUM_CORES  per-core clock-enable
state  output  3  current state encoding
cycle_count  output  CNT_W  enabled cycles since last restart, saturating
done  output  1  high in HALT
timeout  output  1  sticky, set when HALT was caused by budget

Behaviour:
- Only one clock and one async active-low reset; no other resets inside.
- reset low: immediately state=RST_HOLD(0), core_rst_n=0, core_en=0, cycle_count=0, done=0, timeout=0, hold counter=0, step counter=0.
- Reset release is synchronized by a 2-flop synchronizer inside the block; assertion stays asynchronous.
- States: RST_HOLD=0, IDLE=1, RUN=2, PAUSE=3, STEP=4, HALT=5; 6 and 7 go to HALT.
- RST_HOLD:
  - core_rst_n=0.
  - Hold counter counts edges once the synced reset is high; after RST_HOLD edges, go to IDLE and drive core_rst_n all-ones on the same edge.
  - From reset rising to core_rst_n high is 2+RST_HOLD edges.
- core_en = core_mask when state is RUN or STEP, else 0. It is a combinational decode of the state register.
- IDLE:
  - start & !step_mode -> RUN.
  - start & step_mode -> PAUSE.
  - stop -> HALT.
- RUN:
  - Priority: stop -> HALT; then budget hit -> HALT with timeout=1; then step_mode -> PAUSE.
- PAUSE:
  - Priority: stop -> HALT; then step_req -> STEP, loading step counter = max(step_count,1); then start & !step_mode -> RUN.
- STEP:
  - Step counter decrements each edge; at 1 -> PAUSE.
  - stop and budget hit override the step counter, with the same priority as in RUN.
  - A step burst of N yields exactly N cycles with core_en high.
- cycle_count:
  - +1 on every edge where state is RUN or STEP.
  - Saturates at 2^CNT_W-1.
- Budget hit: max_cycles!=0 and cycle_count+1==max_cycles on that edge. This yields exactly max_cycles enabled cycles, then HALT.
- max_cycles changed below the current cycle_count: no hit; the run continues until stop.
- HALT:
  - done=1, core_en=0.
  - start -> RST_HOLD (soft restart): core_rst_n=0 for RST_HOLD edges; cycle_count, done and timeout cleared on entry.
- step_req outside PAUSE is ignored. step_req held high re-triggers a burst on each PAUSE entry.
- reset asserted mid-burst or mid-run: all state discarded immediately, with the reset values above.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state encoding constants (RST_HOLD..HALT, width 3)
  - default parameter values
- One natural sub-module: reset_sync (2-flop async-assert/sync-release synchronizer), reused elsewhere for the cores.
- Remaining logic is a single FSM plus counters.

Test Plan:
- Reset release with RST_HOLD=4, NUM_CORES=2 -> core_rst_n=2'b00 for 6 edges after reset rises, then 2'b11; state=1; core_en=0.
- Free run: start=1, step_mode=0, max_cycles=10, core_mask=2'b11 -> core_en=2'b11 for exactly 10 cycles; then state=5, done=1, timeout=1, cycle_count=10.
- Stepping: step_mode=1, start, then step_req with step_count=3, then step_count=0 -> 3 enabled cycles, PAUSE, then 1 enabled cycle; cycle_count=4.
- Stop priority: stop asserted on the same edge as a budget hit in RUN -> HALT with timeout=0. A mask of 2'b01 during RUN gives core_en=2'b01.
- Restart from HALT: start -> core_rst_n low 4 edges, cycle_count=0, done=0, timeout=0, state=1.
- Async reset mid-STEP (step_count=5, after 2 cycles) -> core_en=0 and core_rst_n=0 immediately without a clock edge; all outputs at reset values.
